fc_ctrl: RTL

FC_CTRL -- requirements
Module: fc_ctrl

---
 rtl/fc_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fc_ctrl.sv
// Sequencer for a fully-connected neuron: streams weights from ROM, issues
// feature beats over several passes, waits for the neuron result and hands it off.
module fc_ctrl #(
    parameter int NWEIGHT  = 192,
    parameter int NBEAT    = 16,
    parameter int NPASS    = 2,
    parameter int BEAT_GAP = 1,
    parameter int PASS_GAP = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_start,
    input  logic        run_start,
    output logic [7:0]  w_rd_addr,
    output logic        fc_weight_en,
    output logic [4:0]  f_rd_addr,
    output logic        fc_ivalid,
    input  logic        fc_ovalid,
    input  logic [31:0] fc_dout,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy,
    output logic        wloaded,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        RUN   = 3'd2,
        PGAP  = 3'd3,
        WAIT  = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic [7:0] LAST_W    = 8'(NWEIGHT - 1);
    localparam logic [3:0] LAST_BEAT = 4'(NBEAT - 1);
    localparam logic       LAST_PASS = 1'(NPASS - 1);
    localparam logic [7:0] BGAP      = 8'(BEAT_GAP);
    // PGAP is entered straight from the last strobe, so it also absorbs the beat gap
    localparam logic [7:0] PGAP_LAST = 8'(BEAT_GAP + PASS_GAP - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [7:0]  w_addr_reg;
    logic [3:0]  beat_reg;
    logic        pass_reg;
    logic        wen_reg;
    logic        wlast_reg;
    logic        ivalid_reg;
    logic        wloaded_reg;
    logic        err_reg;
    logic [31:0] res_data_reg;

    logic f_strobe;
    logic accept_load;
    logic accept_run;
    logic run_reject;
    logic timeout;

    assign f_strobe    = (state_reg == RUN) && (cnt_reg == 8'd0);
    assign accept_load = (state_reg == IDLE) && load_start;
    assign accept_run  = (state_reg == IDLE) && !load_start && run_start && wloaded_reg;
    assign run_reject  = (state_reg == IDLE) && !load_start && run_start && !wloaded_reg;
    assign timeout     = (state_reg == WAIT) && !fc_ovalid && (cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_load)     state_next = WLOAD;
                else if (accept_run) state_next = RUN;
            end
            WLOAD: if (w_addr_reg == LAST_W) state_next = IDLE;
            RUN: begin
                if (f_strobe && beat_reg == LAST_BEAT)
                    state_next = (pass_reg == LAST_PASS) ? WAIT : PGAP;
            end
            PGAP: if (cnt_reg == PGAP_LAST) state_next = RUN;
            WAIT: begin
                if (fc_ovalid)    state_next = OUT;
                else if (timeout) state_next = IDLE;
            end
            OUT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg      <= 8'd0;
            w_addr_reg   <= 8'd0;
            beat_reg     <= 4'd0;
            pass_reg     <= 1'b0;
            wen_reg      <= 1'b0;
            wlast_reg    <= 1'b0;
            ivalid_reg   <= 1'b0;
            wloaded_reg  <= 1'b0;
            err_reg      <= 1'b0;
            res_data_reg <= 32'd0;
        end else begin
            if (state_next != state_reg) begin
                cnt_reg <= 8'd0;
            end else begin
                case (state_reg)
                    RUN:       cnt_reg <= (cnt_reg == BGAP) ? 8'd0 : cnt_reg + 8'd1;
                    PGAP, WAIT: cnt_reg <= cnt_reg + 8'd1;
                    default:   cnt_reg <= 8'd0;
                endcase
            end

            if (state_reg == WLOAD)
                w_addr_reg <= (w_addr_reg == LAST_W) ? 8'd0 : w_addr_reg + 8'd1;

            // beat/pass advance after each strobe and wrap to 0 after the final beat
            if (f_strobe) begin
                if (beat_reg == LAST_BEAT) begin
                    beat_reg <= 4'd0;
                    pass_reg <= (pass_reg == LAST_PASS) ? 1'b0 : pass_reg + 1'b1;
                end else begin
                    beat_reg <= beat_reg + 4'd1;
                end
            end

            wen_reg    <= (state_reg == WLOAD);
            wlast_reg  <= (state_reg == WLOAD) && (w_addr_reg == LAST_W);
            ivalid_reg <= f_strobe;

            if (accept_load)    wloaded_reg <= 1'b0;
            else if (wlast_reg) wloaded_reg <= 1'b1;

            if (run_reject || timeout) err_reg <= 1'b1;

            if (state_reg == WAIT && fc_ovalid) res_data_reg <= fc_dout;
        end
    end

    assign w_rd_addr    = w_addr_reg;
    assign fc_weight_en = wen_reg;
    assign f_rd_addr    = {pass_reg, beat_reg};
    assign fc_ivalid    = ivalid_reg;
    assign res_valid    = (state_reg == OUT);
    assign res_data     = res_data_reg;
    assign busy         = (state_reg != IDLE);
    assign wloaded      = wloaded_reg;
    assign err          = err_reg;

endmodule
